sif_regfile_fwd: RTL and testbench
==================================

# sif_regfile_fwd

Parametrised SIF slave and the next generation of the SIF example DUT. It holds a 2**ADDR_W-entry register bank that the external-access (xa) side reads and writes. Every xa write is also queued and forwarded to the write-access (wa) side through a FIFO with a ready/valid handshake, so wa back-pressure no longer loses data silently. It sits between the SIF test/host side and a downstream consumer of write notifications.

## Interface

Parameters:
- DATA_W, 16: data width of the register bank, xa data and wa data.
- ADDR_W, 4: address width; the bank depth is 2**ADDR_W, so every address is valid.
- FIFO_DEPTH, 4: forward-queue entries; a power of two, at least 2.
- WA_ADDR_OFS, 0: constant added to the forwarded address, modulo 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- xa_wr_s  in  1  xa write strobe, one word per cycle.
- xa_rd_s  in  1  xa read strobe.
- xa_addr  in  ADDR_W  xa address.
- xa_data_wr  in  DATA_W  xa write data.
- xa_data_rd  out  DATA_W  read data, registered.
- xa_rd_vld  out  1  xa_data_rd is valid this cycle.
- xa_full  out  1  forward FIFO is full.
- wa_wr_s  out  1  forward entry valid (FIFO not empty).
- wa_addr  out  ADDR_W  forwarded address.
- wa_data_wr  out  DATA_W  forwarded data.
- wa_ready  in  1  consumer accepts the current entry.
- fifo_lvl  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.

## Operation

- Reset, asynchronous while rst=1:
  - The bank is all zeros.
  - FIFO is empty, pointers are zero.
  - xa_data_rd=0, xa_rd_vld=0, xa_full=0, wa_wr_s=0, wa_addr=0, wa_data_wr=0, fifo_lvl=0, ovf=0.
  - Reset asserted mid-transfer discards all queued entries. No wa_wr_s is ever asserted from stale content.
- xa write (xa_wr_s=1):
  - bank[xa_addr] is updated at the clock edge. The bank is always written, whatever the FIFO state.
  - The entry {(xa_addr+WA_ADDR_OFS) mod 2**ADDR_W, xa_data_wr} is pushed if the FIFO has space.
- xa read (xa_rd_s=1): xa_data_rd <= bank[xa_addr] and xa_rd_vld <= 1. Otherwise xa_rd_vld <= 0 and xa_data_rd holds its last value.
- Read and write to the same address in one cycle: the read returns the old content (read-before-write).
- FIFO handshake:
  - wa_wr_s = (fifo_lvl != 0). wa_addr and wa_data_wr present the head entry, or 0 when the FIFO is empty.
  - A pop happens when wa_wr_s && wa_ready.
  - While wa_wr_s=1 and wa_ready=0, the head entry is held stable.
- Push and pop in the same cycle: fifo_lvl is unchanged. When the FIFO is full, a simultaneous pop frees the slot, so the push is accepted and there is no overflow.
- Overflow: a push with fifo_lvl==FIFO_DEPTH and no pop in the same cycle drops the entry and sets ovf <= 1.
- ovf_clr=1 clears ovf, except when an overflow happens in the same cycle; set wins.
- xa_full = (fifo_lvl==FIFO_DEPTH), combinational from the level register.
- Pointers wrap modulo FIFO_DEPTH. fifo_lvl ranges 0..FIFO_DEPTH.

## Timing

- xa read latency is 1 cycle: data is sampled in cycle N and appears with xa_rd_vld in cycle N+1. Back-to-back reads are allowed every cycle.
- A write in cycle N is visible to an xa read issued in cycle N+1.
- Forward latency is 1 cycle: a write in cycle N pushed into an empty FIFO gives wa_wr_s=1 in cycle N+1.
- Forward throughput is 1 entry per cycle while wa_ready=1.
- All outputs are registered except xa_full and the wa_* head view, which are decoded from registered state. There is no combinational path from any input to any output.

## Test plan

- Reset, then write 0xA5A5 to address 3 with wa_ready=1, then read address 3:
  - wa_wr_s=1, wa_addr=3, wa_data_wr=0xA5A5 one cycle after the write, then FIFO empty.
  - xa_data_rd=0xA5A5 with xa_rd_vld=1 one cycle after the read.
- Same-address read and write: bank[5]=0x1111, then write 0x2222 and read address 5 in one cycle. The read returns 0x1111; the next read returns 0x2222.
- wa_ready=0, then 5 writes with FIFO_DEPTH=4:
  - xa_full=1 after the 4th write.
  - The 5th write sets ovf and the bank still holds its data.
  - Releasing wa_ready drains exactly the 4 first entries in order.
  - ovf_clr clears ovf.
- Full FIFO, then a push and wa_ready=1 in the same cycle: the push is accepted, fifo_lvl stays 4, ovf stays 0.
- WA_ADDR_OFS=2, ADDR_W=4, write to address 15: wa_addr=1 (wrap-around).
- Assert rst with 3 entries queued and wa_ready=0: wa_wr_s=0, fifo_lvl=0 and every bank address reads 0 after rst drops.

Source files
------------

// File: rtl/sif_regfile_fwd.sv
// SIF slave register bank with a ready/valid forward queue of every xa write.
// The bank is read-before-write; the forward queue holds entries while the consumer is not ready.
module sif_regfile_fwd #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WA_ADDR_OFS = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          xa_wr_s,
  input  logic                          xa_rd_s,
  input  logic [ADDR_W-1:0]             xa_addr,
  input  logic [DATA_W-1:0]             xa_data_wr,
  output logic [DATA_W-1:0]             xa_data_rd,
  output logic                          xa_rd_vld,
  output logic                          xa_full,
  output logic                          wa_wr_s,
  output logic [ADDR_W-1:0]             wa_addr,
  output logic [DATA_W-1:0]             wa_data_wr,
  input  logic                          wa_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int unsigned BANK_DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W      = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fwd_entry_t;

  logic [DATA_W-1:0] bank [BANK_DEPTH];
  fwd_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic       fifo_empty_c;
  logic       fifo_full_c;
  logic       pop_c;
  logic       push_c;
  logic       drop_c;
  fwd_entry_t entry_in_c;
  fwd_entry_t head_c;

  // Handshake decode; a pop on a full queue frees the slot for a same-cycle push.
  always_comb begin
    fifo_empty_c    = (fifo_lvl == '0);
    fifo_full_c     = (fifo_lvl == LVL_W'(FIFO_DEPTH));
    pop_c           = !fifo_empty_c && wa_ready;
    push_c          = xa_wr_s && (!fifo_full_c || pop_c);
    drop_c          = xa_wr_s && fifo_full_c && !pop_c;
    entry_in_c.addr = xa_addr + ADDR_W'(WA_ADDR_OFS);
    entry_in_c.data = xa_data_wr;
    head_c          = fifo_empty_c ? '0 : fifo_mem[rd_ptr];
  end

  assign xa_full    = fifo_full_c;
  assign wa_wr_s    = !fifo_empty_c;
  assign wa_addr    = head_c.addr;
  assign wa_data_wr = head_c.data;

  // Register bank: always written, independent of queue state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BANK_DEPTH); i++) bank[i] <= '0;
    end else if (xa_wr_s) begin
      bank[xa_addr] <= xa_data_wr;
    end
  end

  // Read port samples the pre-write content of the addressed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xa_data_rd <= '0;
      xa_rd_vld  <= 1'b0;
    end else begin
      xa_rd_vld <= xa_rd_s;
      if (xa_rd_s) xa_data_rd <= bank[xa_addr];
    end
  end

  // Queue storage needs no reset: the head view is masked while empty.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= entry_in_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_lvl <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   fifo_lvl <= fifo_lvl + LVL_W'(1);
        2'b01:   fifo_lvl <= fifo_lvl - LVL_W'(1);
        default: fifo_lvl <= fifo_lvl;
      endcase
    end
  end

  // Sticky overflow; a same-cycle drop outranks the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop_c) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sif_regfile_fwd.sv
// Bench for sif_regfile_fwd: directed scenarios plus random traffic against
// an array/queue reference model, compared every cycle.
module tb_sif_regfile_fwd;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned OFS    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              xa_wr_s, xa_rd_s, wa_ready, ovf_clr;
  logic [ADDR_W-1:0] xa_addr;
  logic [DATA_W-1:0] xa_data_wr;
  logic [DATA_W-1:0] xa_data_rd;
  logic              xa_rd_vld, xa_full, wa_wr_s, ovf;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data_wr;
  logic [2:0]        fifo_lvl;

  sif_regfile_fwd #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .WA_ADDR_OFS(OFS)
  ) dut (
    .clk(clk), .rst(rst),
    .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
    .xa_data_wr(xa_data_wr), .xa_data_rd(xa_data_rd), .xa_rd_vld(xa_rd_vld),
    .xa_full(xa_full), .wa_wr_s(wa_wr_s), .wa_addr(wa_addr),
    .wa_data_wr(wa_data_wr), .wa_ready(wa_ready), .fifo_lvl(fifo_lvl),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_W-1:0]        m_bank [16];
  logic [ADDR_W+DATA_W-1:0] m_q [$];
  logic [DATA_W-1:0]        m_rd;
  logic                     m_vld;
  logic                     m_ovf;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bank[i] = '0;
    m_q.delete();
    m_rd  = '0;
    m_vld = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    logic [ADDR_W+DATA_W-1:0] head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    check({tag, ".rd"},   32'(xa_data_rd), 32'(m_rd));
    check({tag, ".vld"},  32'(xa_rd_vld),  32'(m_vld));
    check({tag, ".full"}, 32'(xa_full),    32'(m_q.size() == DEPTH));
    check({tag, ".wa_s"}, 32'(wa_wr_s),    32'(m_q.size() != 0));
    check({tag, ".wa_a"}, 32'(wa_addr),    32'(head[ADDR_W+DATA_W-1:DATA_W]));
    check({tag, ".wa_d"}, 32'(wa_data_wr), 32'(head[DATA_W-1:0]));
    check({tag, ".lvl"},  32'(fifo_lvl),   32'(m_q.size()));
    check({tag, ".ovf"},  32'(ovf),        32'(m_ovf));
  endtask

  // Advance one clock: model the edge from the applied inputs, then compare.
  task automatic cycle(input string tag);
    logic overflow;
    if (rst) begin
      model_reset();
    end else begin
      overflow = 1'b0;
      if (xa_rd_s) m_rd = m_bank[xa_addr];
      m_vld = xa_rd_s;
      if (m_q.size() != 0 && wa_ready) void'(m_q.pop_front());
      if (xa_wr_s) begin
        m_bank[xa_addr] = xa_data_wr;
        if (m_q.size() < DEPTH) m_q.push_back({ADDR_W'(xa_addr + OFS), xa_data_wr});
        else overflow = 1'b1;
      end
      if (overflow) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic rdy, input logic clr);
    xa_wr_s = wr; xa_rd_s = rd; xa_addr = a; xa_data_wr = d; wa_ready = rdy; ovf_clr = clr;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0);
    model_reset();
    cycle("reset0");
    cycle("reset1");
    rst = 1'b0;

    // Basic write, forward with offset, drain, read back
    drive(1, 0, 4'd3, 16'hA5A5, 1, 0); cycle("wr3");
    check("fwd_addr3", 32'(wa_addr), 32'd5);
    drive(0, 0, '0, '0, 1, 0);         cycle("drain3");
    drive(0, 1, 4'd3, '0, 1, 0);       cycle("rd3");
    check("rd3_data", 32'(xa_data_rd), 32'hA5A5);
    drive(0, 0, '0, '0, 1, 0);         cycle("idle0");

    // Read-before-write on the same address
    drive(1, 0, 4'd5, 16'h1111, 1, 0); cycle("wr5a");
    drive(1, 1, 4'd5, 16'h2222, 1, 0); cycle("rw5");
    check("rbw_old", 32'(xa_data_rd), 32'h1111);
    drive(0, 1, 4'd5, '0, 1, 0);       cycle("rd5");
    check("rbw_new", 32'(xa_data_rd), 32'h2222);
    drive(0, 0, '0, '0, 1, 0);         cycle("idle1");

    // Fill with back-pressure, overflow on the fifth write
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, ADDR_W'(i), DATA_W'(16'hB000 + i), 0, 0);
      cycle("fill");
      if (i == 3) check("full_after4", 32'(xa_full), 32'd1);
    end
    check("ovf_set", 32'(ovf), 32'd1);
    drive(0, 1, 4'd4, '0, 0, 0);       cycle("rd_ovf_word");
    check("bank_kept", 32'(xa_data_rd), 32'hB004);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, '0, '0, 1, 0);
      check("drain_head", 32'(wa_data_wr), 32'(16'hB000 + i));
      cycle("drain");
    end
    check("drained_empty", 32'(wa_wr_s), 32'd0);
    drive(0, 0, '0, '0, 1, 1);         cycle("ovf_clr");
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Full queue: push with simultaneous pop is accepted
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, ADDR_W'(8 + i), DATA_W'(16'hC000 + i), 0, 0);
      cycle("fill2");
    end
    drive(1, 0, 4'd12, 16'hC0DE, 1, 0); cycle("push_pop_full");
    check("pp_lvl", 32'(fifo_lvl), 32'd4);
    check("pp_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, '0, '0, 1, 0); cycle("drain2");
    end

    // Address wrap of the forwarded address
    drive(1, 0, 4'd15, 16'h0F0F, 1, 0); cycle("wr15");
    check("wrap_addr", 32'(wa_addr), 32'd1);
    drive(0, 0, '0, '0, 1, 0);          cycle("drain15");

    // Reset with queued entries under back-pressure
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, ADDR_W'(i + 1), DATA_W'(16'hD000 + i), 0, 0);
      cycle("q3");
    end
    check("q3_lvl", 32'(fifo_lvl), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_wa_s", 32'(wa_wr_s), 32'd0);
    check("arst_lvl", 32'(fifo_lvl), 32'd0);
    drive(0, 0, '0, '0, 0, 0);
    cycle("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, ADDR_W'(i), '0, 0, 0);
      cycle("rd_zero");
      check("bank_zero", 32'(xa_data_rd), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ADDR_W'($urandom), DATA_W'($urandom),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0));
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
